// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset controller (addu, subu, ori, lui, lw, sw, beq, j).
// The state register is the only storage; every control output is decoded
// combinationally from the current state plus the op/funct/Zero inputs.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       Zero,
    output logic       PCWr,
    output logic [1:0] NPCOp,
    output logic       IRWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic [1:0] RegDst,
    output logic       WDSel,
    output logic       ALUSrc,
    output logic [1:0] ExtOp,
    output logic [2:0] ALUctr,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH = 4'd0,
        DCD   = 4'd1,
        MA    = 4'd2,
        MR    = 4'd3,
        MW    = 4'd4,
        MWB   = 4'd5,
        EXE   = 4'd6,
        AWB   = 4'd7,
        BR    = 4'd8,
        JMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] FN_ADDU   = 6'b100001;
    localparam logic [5:0] FN_SUBU   = 6'b100011;

    state_t state_q;
    state_t state_d;

    logic is_addu;
    logic is_subu;
    logic is_ori;
    logic is_lui;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic is_rtype;
    logic is_alu;

    logic [2:0] exe_aluctr;
    logic       exe_alusrc;

    // Instruction decode from the IR fields, which stay stable after FETCH.
    always_comb begin
        is_addu  = (op == OP_RTYPE) && (funct == FN_ADDU);
        is_subu  = (op == OP_RTYPE) && (funct == FN_SUBU);
        is_ori   = (op == OP_ORI);
        is_lui   = (op == OP_LUI);
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_beq   = (op == OP_BEQ);
        is_j     = (op == OP_J);
        is_rtype = is_addu || is_subu;
        is_alu   = is_rtype || is_ori || is_lui;
    end

    // ALU setup shared by EXE and AWB so the result stays valid through write-back.
    always_comb begin
        exe_aluctr = 3'b000;
        exe_alusrc = 1'b0;
        if (is_subu) begin
            exe_aluctr = 3'b001;
        end else if (is_ori) begin
            exe_aluctr = 3'b010;
            exe_alusrc = 1'b1;
        end else if (is_lui) begin
            exe_aluctr = 3'b011;
            exe_alusrc = 1'b1;
        end
    end

    // Next-state selection; unused codes and anything unexpected fall back to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DCD;
            DCD: begin
                if (is_lw || is_sw) begin
                    state_d = MA;
                end else if (is_alu) begin
                    state_d = EXE;
                end else if (is_beq) begin
                    state_d = BR;
                end else if (is_j) begin
                    state_d = JMP;
                end else begin
                    state_d = FETCH;
                end
            end
            MA: begin
                if (is_lw) begin
                    state_d = MR;
                end else if (is_sw) begin
                    state_d = MW;
                end else begin
                    state_d = FETCH;
                end
            end
            MR:      state_d = MWB;
            MWB:     state_d = FETCH;
            MW:      state_d = FETCH;
            EXE:     state_d = AWB;
            AWB:     state_d = FETCH;
            BR:      state_d = FETCH;
            JMP:     state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Control outputs per state; write enables are masked while reset is held
    // so an aborted lw/sw can never write the register file or memory.
    always_comb begin
        PCWr    = 1'b0;
        NPCOp   = 2'b00;
        IRWr    = 1'b0;
        RFWr    = 1'b0;
        DMWr    = 1'b0;
        RegDst  = 2'b00;
        WDSel   = 1'b0;
        ALUSrc  = 1'b0;
        ExtOp   = 2'b00;
        ALUctr  = 3'b000;
        illegal = 1'b0;
        case (state_q)
            FETCH: begin
                IRWr = 1'b1;
                PCWr = 1'b1;
            end
            DCD: begin
                illegal = !(is_lw || is_sw || is_alu || is_beq || is_j);
            end
            MA: begin
                ALUSrc = 1'b1;
                ExtOp  = 2'b01;
            end
            MW: begin
                ALUSrc = 1'b1;
                ExtOp  = 2'b01;
                DMWr   = 1'b1;
            end
            MWB: begin
                RFWr  = 1'b1;
                WDSel = 1'b1;
            end
            EXE: begin
                ALUctr = exe_aluctr;
                ALUSrc = exe_alusrc;
            end
            AWB: begin
                ALUctr = exe_aluctr;
                ALUSrc = exe_alusrc;
                RFWr   = 1'b1;
                RegDst = is_rtype ? 2'b01 : 2'b00;
            end
            BR: begin
                ALUctr = 3'b001;
                NPCOp  = 2'b01;
                PCWr   = Zero;
            end
            JMP: begin
                PCWr  = 1'b1;
                NPCOp = 2'b10;
            end
            default: begin
            end
        endcase
        if (rst) begin
            PCWr    = 1'b0;
            IRWr    = 1'b0;
            RFWr    = 1'b0;
            DMWr    = 1'b0;
            illegal = 1'b0;
        end
    end

    // State register; reset returns to FETCH without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed self-checking bench for the multi-cycle controller.
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       Zero;
    logic       PCWr;
    logic [1:0] NPCOp;
    logic       IRWr;
    logic       RFWr;
    logic       DMWr;
    logic [1:0] RegDst;
    logic       WDSel;
    logic       ALUSrc;
    logic [1:0] ExtOp;
    logic [2:0] ALUctr;
    logic       illegal;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;
    int dm_edges = 0;

    mc_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .op      (op),
        .funct   (funct),
        .Zero    (Zero),
        .PCWr    (PCWr),
        .NPCOp   (NPCOp),
        .IRWr    (IRWr),
        .RFWr    (RFWr),
        .DMWr    (DMWr),
        .RegDst  (RegDst),
        .WDSel   (WDSel),
        .ALUSrc  (ALUSrc),
        .ExtOp   (ExtOp),
        .ALUctr  (ALUctr),
        .illegal (illegal),
        .state   (state)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every clock edge at which a memory write would be committed.
    always @(posedge clk) begin
        if (DMWr) dm_edges++;
    end

    // Advance one cycle and land on the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; op = 6'b111111; funct = 6'b0; Zero = 1'b0;
        @(negedge clk);
        tick();
        total++;
        if (state !== 4'd0) begin
            bad++; $display("[TB] FAIL reset_state got=%0d exp=0", state);
        end
        total++;
        if ({PCWr, IRWr, RFWr, DMWr, illegal} !== 5'b00000) begin
            bad++; $display("[TB] FAIL reset_enables got=%b exp=00000", {PCWr, IRWr, RFWr, DMWr, illegal});
        end
        rst = 1'b0;
        #1;
        total++;
        if ({IRWr, PCWr, NPCOp, ALUctr, RFWr, DMWr} !== 9'b1_1_00_000_0_0) begin
            bad++; $display("[TB] FAIL fetch_ctrl got=%b exp=110000000", {IRWr, PCWr, NPCOp, ALUctr, RFWr, DMWr});
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_s [5] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd0};
        op = 6'b100011;
        foreach (exp_s[i]) begin
            tick();
            total++;
            if (state !== exp_s[i]) begin
                bad++; $display("[TB] FAIL lw_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]);
            end
            total++;
            if ({RFWr, WDSel, DMWr} !== {exp_s[i] == 4'd5, exp_s[i] == 4'd5, 1'b0}) begin
                bad++; $display("[TB] FAIL lw_wr[%0d] got=%b exp=%b", i, {RFWr, WDSel, DMWr}, {exp_s[i] == 4'd5, exp_s[i] == 4'd5, 1'b0});
            end
            if (exp_s[i] == 4'd2) begin
                total++;
                if ({ALUSrc, ExtOp, ALUctr} !== 6'b1_01_000) begin
                    bad++; $display("[TB] FAIL lw_ma got=%b exp=101000", {ALUSrc, ExtOp, ALUctr});
                end
            end
        end
    endtask

    task automatic test_subu();
        logic [3:0] exp_s [4] = '{4'd1, 4'd6, 4'd7, 4'd0};
        op = 6'b000000; funct = 6'b100011;
        foreach (exp_s[i]) begin
            tick();
            total++;
            if (state !== exp_s[i]) begin
                bad++; $display("[TB] FAIL subu_state[%0d] got=%0d exp=%0d", i, state, exp_s[i]);
            end
            if (exp_s[i] == 4'd6 || exp_s[i] == 4'd7) begin
                total++;
                if ({ALUctr, ALUSrc} !== 4'b001_0) begin
                    bad++; $display("[TB] FAIL subu_alu got=%b exp=0010", {ALUctr, ALUSrc});
                end
            end
            total++;
            if ({RFWr, RegDst} !== ((exp_s[i] == 4'd7) ? 3'b1_01 : 3'b0_00)) begin
                bad++; $display("[TB] FAIL subu_wb[%0d] got=%b exp=%b", i, {RFWr, RegDst}, (exp_s[i] == 4'd7) ? 3'b101 : 3'b000);
            end
        end
        funct = 6'b0;
    endtask

    task automatic test_beq();
        logic zv [2] = '{1'b1, 1'b0};
        op = 6'b000100;
        foreach (zv[i]) begin
            Zero = zv[i];
            tick();
            tick();
            total++;
            if ({state, PCWr, NPCOp, ALUctr, ALUSrc} !== {4'd8, zv[i], 2'b01, 3'b001, 1'b0}) begin
                bad++; $display("[TB] FAIL beq_br[z=%0d] got=%b exp=%b", zv[i], {state, PCWr, NPCOp, ALUctr, ALUSrc}, {4'd8, zv[i], 2'b01, 3'b001, 1'b0});
            end
            tick();
            total++;
            if (state !== 4'd0) begin
                bad++; $display("[TB] FAIL beq_ret[z=%0d] got=%0d exp=0", zv[i], state);
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_lui_ori();
        logic [5:0] ops [2] = '{6'b001111, 6'b001101};
        logic [2:0] alu [2] = '{3'b011, 3'b010};
        foreach (ops[i]) begin
            op = ops[i];
            tick();
            tick();
            total++;
            if ({state, ALUctr, ALUSrc, ExtOp} !== {4'd6, alu[i], 1'b1, 2'b00}) begin
                bad++; $display("[TB] FAIL imm_exe[%0d] got=%b exp=%b", i, {state, ALUctr, ALUSrc, ExtOp}, {4'd6, alu[i], 1'b1, 2'b00});
            end
            tick();
            total++;
            if ({state, ALUctr, ALUSrc, ExtOp, RegDst, RFWr, WDSel} !== {4'd7, alu[i], 1'b1, 2'b00, 2'b00, 1'b1, 1'b0}) begin
                bad++; $display("[TB] FAIL imm_awb[%0d] got=%b exp=%b", i, {state, ALUctr, ALUSrc, ExtOp, RegDst, RFWr, WDSel}, {4'd7, alu[i], 1'b1, 2'b00, 2'b00, 1'b1, 1'b0});
            end
            tick();
        end
    endtask

    task automatic test_sw_and_jump();
        op = 6'b101011;
        tick();
        tick();
        tick();
        total++;
        if ({state, DMWr, RFWr, ALUSrc, ExtOp, ALUctr} !== {4'd4, 1'b1, 1'b0, 1'b1, 2'b01, 3'b000}) begin
            bad++; $display("[TB] FAIL sw_mw got=%b exp=%b", {state, DMWr, RFWr, ALUSrc, ExtOp, ALUctr}, {4'd4, 1'b1, 1'b0, 1'b1, 2'b01, 3'b000});
        end
        tick();
        total++;
        if (state !== 4'd0) begin
            bad++; $display("[TB] FAIL sw_ret got=%0d exp=0", state);
        end
        op = 6'b000010;
        tick();
        tick();
        total++;
        if ({state, PCWr, NPCOp} !== {4'd9, 1'b1, 2'b10}) begin
            bad++; $display("[TB] FAIL j_jmp got=%b exp=%b", {state, PCWr, NPCOp}, {4'd9, 1'b1, 2'b10});
        end
        tick();
        total++;
        if (state !== 4'd0) begin
            bad++; $display("[TB] FAIL j_ret got=%0d exp=0", state);
        end
    endtask

    task automatic test_illegal();
        logic [11:0] bad_ir [2] = '{{6'b111111, 6'b000000}, {6'b000000, 6'b000000}};
        foreach (bad_ir[i]) begin
            {op, funct} = bad_ir[i];
            tick();
            total++;
            if ({state, illegal, PCWr, IRWr, RFWr, DMWr} !== {4'd1, 1'b1, 4'b0000}) begin
                bad++; $display("[TB] FAIL illegal_dcd[%0d] got=%b exp=%b", i, {state, illegal, PCWr, IRWr, RFWr, DMWr}, {4'd1, 1'b1, 4'b0000});
            end
            tick();
            total++;
            if ({state, illegal} !== {4'd0, 1'b0}) begin
                bad++; $display("[TB] FAIL illegal_next[%0d] got=%b exp=%b", i, {state, illegal}, {4'd0, 1'b0});
            end
        end
        funct = 6'b0;
    endtask

    task automatic test_reset_mid_sw();
        int edges_before;
        op = 6'b101011;
        tick();
        tick();
        tick();
        edges_before = dm_edges;
        total++;
        if ({state, DMWr} !== {4'd4, 1'b1}) begin
            bad++; $display("[TB] FAIL rstmw_pre got=%b exp=%b", {state, DMWr}, {4'd4, 1'b1});
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({state, DMWr, PCWr, IRWr, RFWr} !== {4'd0, 4'b0000}) begin
            bad++; $display("[TB] FAIL rstmw_async got=%b exp=%b", {state, DMWr, PCWr, IRWr, RFWr}, {4'd0, 4'b0000});
        end
        tick();
        rst = 1'b0;
        op = 6'b000010;
        #1;
        total++;
        if (dm_edges !== edges_before) begin
            bad++; $display("[TB] FAIL rstmw_nowrite got=%0d exp=%0d", dm_edges, edges_before);
        end
        tick();
        total++;
        if (state !== 4'd1) begin
            bad++; $display("[TB] FAIL rstmw_refetch got=%0d exp=1", state);
        end
        tick();
        tick();
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_lw();
        test_subu();
        test_beq();
        test_lui_ori();
        test_sw_and_jump();
        test_illegal();
        test_reset_mid_sw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #20000;
        $display("[TB] FAIL timeout got=stalled exp=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-002 The block SHALL have these remaining ports: op  input  6  IR[31:26]; funct  input  6  IR[5:0]; Zero  input  1  ALU zero flag.
REQ-003 The block SHALL drive these outputs: PCWr  output  1  PC write enable; NPCOp  output  2  next-PC select (00 PC+4, 01 branch, 10 jump); IRWr  output  1  IR load.
REQ-004 The block SHALL drive these outputs: RFWr  output  1  register-file write; DMWr  output  1  data-memory write; RegDst  output  2  write register (00 rt, 01 rd).
REQ-005 The block SHALL drive these outputs: WDSel  output  1  RF write data (0 ALU, 1 memory); ALUSrc  output  1  ALU B (0 register, 1 extended immediate); ExtOp  output  2  extender mode (00 zero, 01 sign).
REQ-006 The block SHALL drive these outputs: ALUctr  output  3  ALU operation (000 add, 001 sub, 010 or, 011 lui); illegal  output  1  one-cycle pulse on unsupported instruction; state  output  4  current FSM state.

Function
REQ-007 The block SHALL be a Moore-style multi-cycle controller; outputs SHALL be combinational from the state register and the op/funct/Zero inputs only.
REQ-008 State encodings SHALL be FETCH=0, DCD=1, MA=2, MR=3, MW=4, MWB=5, EXE=6, AWB=7, BR=8, JMP=9; codes 10-15 SHALL go to FETCH on the next edge.
REQ-009 The supported set SHALL be addu (op 000000, funct 100001), subu (op 000000, funct 100011), ori (001101), lui (001111), lw (100011), sw (101011), beq (000100) and j (000010).
REQ-010 FETCH SHALL assert IRWr=1, PCWr=1, NPCOp=00 and ALUctr=000, and SHALL go to DCD.
REQ-011 DCD SHALL go as follows: lw/sw to MA; addu/subu/ori/lui to EXE; beq to BR; j to JMP; any other op/funct to FETCH with illegal=1 for that cycle.
REQ-012 MA SHALL drive ALUSrc=1, ExtOp=01, ALUctr=000, and SHALL go to MR for lw and to MW for sw.
REQ-013 MR SHALL go to MWB; MWB SHALL assert RFWr=1, WDSel=1, RegDst=00, then go to FETCH (lw = 5 cycles).
REQ-014 MW SHALL assert DMWr=1, hold the MA ALU controls, then go to FETCH (sw = 4 cycles).
REQ-015 EXE SHALL drive ALUctr as follows: addu 000/ALUSrc=0; subu 001/ALUSrc=0; ori 010/ALUSrc=1/ExtOp=00; lui 011/ALUSrc=1/ExtOp=00. EXE SHALL then go to AWB.
REQ-016 AWB SHALL hold the EXE ALU controls and assert RFWr=1, WDSel=0, RegDst=01 for R-type and 00 for ori/lui, then go to FETCH (4 cycles).
REQ-017 BR SHALL drive ALUctr=001, ALUSrc=0, NPCOp=01 and PCWr=Zero, then go to FETCH (3 cycles, taken or not).
REQ-018 JMP SHALL assert PCWr=1 and NPCOp=10, then go to FETCH (3 cycles).
REQ-019 Outputs not stated for a state SHALL be 0: PCWr, IRWr, RFWr, DMWr, illegal, WDSel, ALUSrc, NPCOp=00, RegDst=00, ExtOp=00, ALUctr=000.
REQ-020 At most one of RFWr and DMWr SHALL be high in any cycle, and neither SHALL be high in FETCH or DCD.
REQ-021 op/funct SHALL be sampled only in DCD, EXE, AWB, MA and BR; the controller SHALL rely on IR staying stable after the FETCH edge.

Reset
REQ-022 rst=1 SHALL force state to FETCH immediately, without waiting for clk.
REQ-023 While rst=1, all write enables (PCWr, IRWr, RFWr, DMWr) and illegal SHALL be 0.
REQ-024 On the first rising clk edge after rst falls, FETCH SHALL perform a normal fetch.
REQ-025 Reset asserted in any state, including mid-lw in MR or mid-sw in MW, SHALL abort the instruction with no RF or memory write.

Verification
REQ-026 Bench: lw (op 100011) from reset -> states 0,1,2,3,5,0; RFWr=1 and WDSel=1 only in state 5.
REQ-027 Bench: subu (op 0, funct 100011) -> states 0,1,6,7,0; ALUctr=001 in 6/7; RFWr=1 and RegDst=01 in 7.
REQ-028 Bench: beq with Zero=1 then Zero=0 -> PCWr=1, NPCOp=01 in state 8 for the first; PCWr=0 for the second; both return to 0.
REQ-029 Bench: lui then ori -> ALUctr=011 and 010 respectively, ALUSrc=1, ExtOp=00, RegDst=00 in AWB.
REQ-030 Bench: op 111111 -> illegal=1 for one cycle in DCD, next state 0, no write enable asserted.
REQ-031 Bench: rst pulsed mid-cycle while in MW -> state=0 before the next edge, DMWr drops to 0 at once, and no memory write occurs.
